xgmii_rx_frame_monitor: RTL and testbench

Passive XGMII receive-side frame checker for the 64-bit 10GBASE-R datapath; it sits on `xgmii_rxd`/`xgmii_rxc` at the output of `eth_phy_10g`. It is the consumer end of the XGMII stream that benches and MACs produce on the transmit side. Per frame it:
- delineates the frame (start control character 0xFB in lane 0 or lane 4, terminate 0xFD),
- checks the preamble and SFD,
- counts the bytes after the SFD,
- reports a one-cycle per-frame status record and keeps running frame and error counters.

---
 rtl/xgmii_rx_frame_monitor_if.sv | 22 ++
 rtl/xgmii_rx_frame_monitor.sv | 204 ++++++++++++++++++++
 tb/tb_xgmii_rx_frame_monitor.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/xgmii_rx_frame_monitor_if.sv
// XGMII receive bus plus the per-frame status record produced by the frame monitor.
// The PHY/bench side is the master; the monitor is the slave.
interface xgmii_rx_frame_monitor_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] xgmii_rxd;
  logic [CTRL_WIDTH-1:0] xgmii_rxc;
  logic                  frame_valid;
  logic [15:0]           frame_len;
  logic [4:0]            frame_err;

  modport master (
    output xgmii_rxd, xgmii_rxc,
    input  frame_valid, frame_len, frame_err
  );

  modport slave (
    input  xgmii_rxd, xgmii_rxc,
    output frame_valid, frame_len, frame_err
  );
endinterface

// File: rtl/xgmii_rx_frame_monitor.sv
// Passive 64-bit XGMII RX frame checker: delineates frames, checks preamble/SFD,
// measures length after SFD and emits a registered status record plus running counters.
module xgmii_rx_frame_monitor #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int MIN_LEN    = 64,
  parameter int MAX_LEN    = 1518
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  input  logic                            clear_counters,
  xgmii_rx_frame_monitor_if.slave         xif,
  output logic                            in_frame,
  output logic [31:0]                     frame_count,
  output logic [15:0]                     error_count
);

  localparam logic [7:0] C_START = 8'hFB;
  localparam logic [7:0] C_TERM  = 8'hFD;
  localparam logic [7:0] C_PRE   = 8'h55;
  localparam logic [7:0] C_SFD   = 8'hD5;

  typedef enum logic [1:0] {ST_IDLE, ST_PRE2, ST_PAYLOAD} state_t;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {13'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] a);
    return (a == 32'hFFFF_FFFF) ? a : a + 32'd1;
  endfunction

  logic [DATA_WIDTH/8-1:0][7:0] lane;
  logic [CTRL_WIDTH-1:0]        rxc;

  assign lane = xif.xgmii_rxd;
  assign rxc  = xif.xgmii_rxc;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic        perr_q, perr_d;
  logic        frame_valid_q, frame_valid_d;
  logic [15:0] frame_len_q, frame_len_d;
  logic [4:0]  frame_err_q, frame_err_d;
  logic        in_frame_q, in_frame_d;
  logic [31:0] frame_count_q, frame_count_d;
  logic [15:0] error_count_q, error_count_d;

  logic        start0, start4, pre0_ok, pre4_ok, pre2_ok;
  logic [7:0]  ctl_mask;
  logic        ctl_found;
  logic [2:0]  ctl_lane;
  logic [3:0]  data_bytes;
  logic        end_now;
  logic [15:0] end_len;
  logic [2:0]  end_err3;
  logic [4:0]  end_err;

  always_comb begin
    start0  = rxc[0] && (lane[0] == C_START);
    start4  = rxc[4] && (lane[4] == C_START);
    pre0_ok = (rxc[7:1] == 7'd0) && (lane[1] == C_PRE) && (lane[2] == C_PRE) &&
              (lane[3] == C_PRE) && (lane[4] == C_PRE) && (lane[5] == C_PRE) &&
              (lane[6] == C_PRE) && (lane[7] == C_SFD);
    pre4_ok = (rxc[7:5] == 3'd0) && (lane[5] == C_PRE) && (lane[6] == C_PRE) &&
              (lane[7] == C_PRE);
    pre2_ok = (rxc[3:0] == 4'd0) && (lane[0] == C_PRE) && (lane[1] == C_PRE) &&
              (lane[2] == C_PRE) && (lane[3] == C_SFD);
  end

  // In PRE2 only the upper half-word carries payload, so the control search starts at lane 4.
  always_comb begin
    ctl_mask  = (state_q == ST_PRE2) ? {rxc[7:4], 4'b0000} : rxc;
    ctl_found = 1'b0;
    ctl_lane  = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (ctl_mask[i]) begin
        ctl_found = 1'b1;
        ctl_lane  = 3'(i);
      end
    end
    if (state_q == ST_PRE2) data_bytes = ctl_found ? ({1'b0, ctl_lane} - 4'd4) : 4'd4;
    else                    data_bytes = ctl_found ? {1'b0, ctl_lane} : 4'd8;
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    perr_d   = perr_q;
    end_now  = 1'b0;
    end_len  = len_q;
    end_err3 = 3'b000;

    case (state_q)
      ST_IDLE: begin
        if (start0) begin
          perr_d  = !pre0_ok;
          len_d   = 16'd0;
          state_d = ST_PAYLOAD;
        end else if (start4) begin
          perr_d  = !pre4_ok;
          len_d   = 16'd0;
          state_d = ST_PRE2;
        end
      end
      ST_PRE2: begin
        if (|rxc[3:0]) begin
          end_now  = 1'b1;
          end_len  = 16'd0;
          end_err3 = 3'b001;
          state_d  = ST_IDLE;
        end else if (ctl_found) begin
          end_now  = 1'b1;
          end_len  = sat_add16(len_q, data_bytes);
          end_err3 = {1'b0, lane[ctl_lane] != C_TERM, perr_q | !pre2_ok};
          state_d  = ST_IDLE;
        end else begin
          len_d   = sat_add16(len_q, data_bytes);
          perr_d  = perr_q | !pre2_ok;
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        // A fresh start truncates the current frame and is itself a new lane-0 start.
        if (start0) begin
          end_now  = 1'b1;
          end_len  = len_q;
          end_err3 = {1'b1, 1'b0, perr_q};
          perr_d   = !pre0_ok;
          len_d    = 16'd0;
        end else if (ctl_found) begin
          end_now  = 1'b1;
          end_len  = sat_add16(len_q, data_bytes);
          end_err3 = {1'b0, lane[ctl_lane] != C_TERM, perr_q};
          state_d  = ST_IDLE;
        end else begin
          len_d = sat_add16(len_q, data_bytes);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable) begin
      state_d = ST_IDLE;
      end_now = 1'b0;
    end
  end

  always_comb begin
    end_err       = {end_len > 16'(MAX_LEN), end_len < 16'(MIN_LEN), end_err3};
    frame_valid_d = end_now;
    frame_len_d   = end_now ? end_len : frame_len_q;
    frame_err_d   = end_now ? end_err : frame_err_q;
    in_frame_d    = (state_d != ST_IDLE);
    frame_count_d = frame_count_q;
    error_count_d = error_count_q;
    if (clear_counters) begin
      frame_count_d = 32'd0;
      error_count_d = 16'd0;
    end else if (end_now) begin
      frame_count_d = sat_inc32(frame_count_q);
      if (|end_err) error_count_d = sat_inc16(error_count_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      len_q         <= 16'd0;
      perr_q        <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_len_q   <= 16'd0;
      frame_err_q   <= 5'd0;
      in_frame_q    <= 1'b0;
      frame_count_q <= 32'd0;
      error_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      perr_q        <= perr_d;
      frame_valid_q <= frame_valid_d;
      frame_len_q   <= frame_len_d;
      frame_err_q   <= frame_err_d;
      in_frame_q    <= in_frame_d;
      frame_count_q <= frame_count_d;
      error_count_q <= error_count_d;
    end
  end

  assign xif.frame_valid = frame_valid_q;
  assign xif.frame_len   = frame_len_q;
  assign xif.frame_err   = frame_err_q;
  assign in_frame        = in_frame_q;
  assign frame_count     = frame_count_q;
  assign error_count     = error_count_q;

endmodule

// File: tb/tb_xgmii_rx_frame_monitor.sv
// Scoreboard bench for xgmii_rx_frame_monitor: directed XGMII words, expected records
// queued at stimulus time and checked by an independent monitor on each frame_valid.
module tb_xgmii_rx_frame_monitor;

  localparam logic [63:0] IDLE_W = 64'h0707070707070707;
  localparam logic [63:0] START0 = 64'hd5555555555555fb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        clear_counters = 1'b0;
  logic        in_frame;
  logic [31:0] frame_count;
  logic [15:0] error_count;

  xgmii_rx_frame_monitor_if xif ();

  xgmii_rx_frame_monitor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .clear_counters (clear_counters),
    .xif            (xif),
    .in_frame       (in_frame),
    .frame_count    (frame_count),
    .error_count    (error_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] len;
    logic [4:0]  err;
    bit          clr;
  } rec_t;

  rec_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   m_frames = 0;
  int   m_errs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected record per frame_valid cycle.
  always @(negedge clk) begin
    if (rst_n && xif.frame_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_frame_valid", 64'd1, 64'd0);
      end else begin
        rec_t r;
        r = exp_q.pop_front();
        chk("frame_len", 64'(xif.frame_len), 64'(r.len));
        chk("frame_err", 64'(xif.frame_err), 64'(r.err));
        if (r.clr) begin
          m_frames = 0;
          m_errs   = 0;
        end else begin
          m_frames++;
          if (r.err != 5'd0) m_errs++;
        end
        chk("frame_count", 64'(frame_count), 64'(m_frames));
        chk("error_count", 64'(error_count), 64'(m_errs));
      end
    end
  end

  task automatic send(input logic [63:0] d, input logic [7:0] c);
    @(posedge clk);
    #1;
    xif.xgmii_rxd = d;
    xif.xgmii_rxc = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(IDLE_W, 8'hFF);
  endtask

  task automatic data(input int n);
    for (int i = 0; i < n; i++) send({32'hA5C30000 + 32'(i), 32'h12345678}, 8'h00);
  endtask

  task automatic term(input int k, input logic [7:0] code);
    logic [63:0] d;
    logic [7:0]  c;
    for (int i = 0; i < 8; i++) begin
      if (i < k) begin
        d[8*i +: 8] = 8'h3C;
        c[i] = 1'b0;
      end else if (i == k) begin
        d[8*i +: 8] = code;
        c[i] = 1'b1;
      end else begin
        d[8*i +: 8] = 8'h07;
        c[i] = 1'b1;
      end
    end
    send(d, c);
  endtask

  task automatic push(input logic [15:0] len, input logic [4:0] err, input bit clr);
    rec_t r;
    r.len = len;
    r.err = err;
    r.clr = clr;
    exp_q.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    xif.xgmii_rxd = IDLE_W;
    xif.xgmii_rxc = 8'hFF;
    repeat (2) @(negedge clk);
    chk("rst_frame_valid", 64'(xif.frame_valid), 64'd0);
    chk("rst_frame_len", 64'(xif.frame_len), 64'd0);
    chk("rst_frame_err", 64'(xif.frame_err), 64'd0);
    chk("rst_in_frame", 64'(in_frame), 64'd0);
    chk("rst_frame_count", 64'(frame_count), 64'd0);
    chk("rst_error_count", 64'(error_count), 64'd0);
    rst_n = 1'b1;
    idle(2);

    // Lane-0 runt
    send(64'hd5555555555555fb, 8'h01);
    send(64'h000dddddaaaddddd, 8'h00);
    chk("in_frame_after_start", 64'(in_frame), 64'd1);
    send(64'h000ecccffccccccc, 8'h00);
    push(16'd23, 5'b01000, 1'b0);
    send(64'hfd2233ee44eeefff, 8'h80);
    idle(3);
    chk("in_frame_after_term", 64'(in_frame), 64'd0);

    // Lane-4 start, good length
    send(64'h555555fb07070707, 8'h1F);
    send(64'h01020304d5555555, 8'h00);
    data(7);
    push(16'd64, 5'b00000, 1'b0);
    term(4, 8'hFD);
    idle(2);

    // Bad SFD
    send(64'hd4555555555555fb, 8'h01);
    data(8);
    push(16'd64, 5'b00001, 1'b0);
    term(0, 8'hFD);
    idle(2);

    // Truncation, then a good frame from the truncating start
    send(START0, 8'h01);
    data(2);
    push(16'd16, 5'b01100, 1'b0);
    send(START0, 8'h01);
    data(8);
    push(16'd64, 5'b00000, 1'b0);
    term(0, 8'hFD);
    idle(2);

    // Error control character ends the frame
    send(START0, 8'h01);
    data(8);
    push(16'd67, 5'b00010, 1'b0);
    send(64'h00000000fe112233, 8'h08);
    idle(2);

    // Giant: 190 words = 1520 bytes
    send(START0, 8'h01);
    data(190);
    push(16'd1520, 5'b10000, 1'b0);
    term(0, 8'hFD);
    idle(2);

    // Lane-4 start aborted by a control byte in the second preamble word
    send(64'h555555fb07070707, 8'h1F);
    push(16'd0, 5'b01001, 1'b0);
    send(IDLE_W, 8'hFF);
    idle(2);

    // Counter clear coinciding with a frame end
    send(START0, 8'h01);
    data(8);
    push(16'd64, 5'b00000, 1'b1);
    term(0, 8'hFD);
    clear_counters = 1'b1;
    idle(1);
    clear_counters = 1'b0;
    idle(2);

    // Reset mid-frame
    send(START0, 8'h01);
    data(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid_in_frame", 64'(in_frame), 64'd0);
    chk("rstmid_frame_valid", 64'(xif.frame_valid), 64'd0);
    chk("rstmid_frame_count", 64'(frame_count), 64'd0);
    m_frames = 0;
    m_errs = 0;
    @(negedge clk);
    rst_n = 1'b1;
    data(5);
    term(0, 8'hFD);
    idle(2);
    send(START0, 8'h01);
    data(8);
    push(16'd64, 5'b00000, 1'b0);
    term(0, 8'hFD);
    idle(2);

    // Enable dropped mid-frame
    send(START0, 8'h01);
    data(3);
    enable = 1'b0;
    data(1);
    chk("enable_low_in_frame", 64'(in_frame), 64'd0);
    enable = 1'b1;
    data(4);
    term(0, 8'hFD);
    idle(2);
    send(START0, 8'h01);
    data(8);
    push(16'd64, 5'b00000, 1'b0);
    term(0, 8'hFD);
    idle(2);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    chk("pending_records", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk("final_frame_count", 64'(frame_count), 64'(m_frames));
    chk("final_error_count", 64'(error_count), 64'(m_errs));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
